fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch (IF) stage and IF/ID pipeline register for the 5-stage RV64 pipeline; sits directly upstream of the decode stage.
- Owns the PC and a word-addressed instruction memory array `instr_mem`, loaded by benches via `$readmemb` on the hierarchical path.
- Presents `instruction_if_id` / `pc_if_id` to ID.
- Honours stall from the hazard unit and redirect/flush from EX.
- Run/halt/fault state machine stops fetch on ECALL or out-of-range PC.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in `instr_mem`; valid PCs are 0 .. IMEM_DEPTH*4-4
- RESET_PC, 64'h0, PC value after reset
- NOP_INSTR, 32'h00000013, bubble encoding (`addi x0,x0,0`)
- HALT_INSTR, 32'h00000073, encoding that halts fetch (ECALL)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  EX: taken branch/jump, flush IF/ID
- redirect_pc  in  64  EX: target PC
- PC  out  64  current fetch PC
- instruction_if_id  out  32  IF/ID instruction
- pc_if_id  out  64  IF/ID PC of that instruction
- valid_if_id  out  1  IF/ID holds a real instruction
- halted  out  1  state == HALT
- fetch_fault  out  1  state == FAULT

Behaviour:
- Reset (reset=0, asynchronous, regardless of clock):
  - PC=RESET_PC, instruction_if_id=NOP_INSTR, pc_if_id=0, valid_if_id=0.
  - State RUN, halted=0, fetch_fault=0.
  - `instr_mem` contents are not cleared.
- Fetch word and range:
  - Fetch word = `instr_mem[PC>>2]`, read combinationally; the IF/ID register captures it on the rising edge. IF→ID latency is 1 cycle.
  - PC in range ⇔ PC < IMEM_DEPTH*4 and PC[1:0]==0.
- States: RUN, HALT, FAULT.
- Per-edge priority, highest first:
  1. redirect_valid=1 (any state, overrides stall): PC<=redirect_pc; instruction_if_id<=NOP_INSTR; valid_if_id<=0; pc_if_id<=0; state<=RUN (cancels a speculative HALT/FAULT).
  2. stall=1: PC and all IF/ID outputs hold; state holds.
  3. State RUN, PC out of range: state<=FAULT; IF/ID<=NOP, valid 0; PC holds.
  4. State RUN, fetch word==HALT_INSTR: IF/ID<=HALT_INSTR, pc_if_id<=PC, valid 1; PC holds; state<=HALT.
  5. State RUN, otherwise: IF/ID<=fetch word, pc_if_id<=PC, valid 1; PC<=PC+4 (64-bit wrap, unreachable in range).
  6. State HALT/FAULT: PC holds; IF/ID<=NOP, valid 0 every cycle until redirect or reset.
- Outputs: halted/fetch_fault are registered and decode state directly.
- Boundary conditions:
  - Redirect to an out-of-range PC: accepted; FAULT is raised on the following edge.
  - Stall and redirect in the same cycle: redirect wins.
  - Reset asserted mid-stall or in HALT: returns to RESET_PC/RUN asynchronously.
  - Last valid word (PC=IMEM_DEPTH*4-4): fetched normally; the next cycle faults.

Optional Feature:
`FETCH_PERF_EN`
- Defined:
  - Adds outputs perf_fetched[31:0], perf_stall[31:0], perf_flush[31:0], reset to 0.
  - perf_fetched increments on each edge that loads valid_if_id=1.
  - perf_stall increments on each edge with stall=1 and redirect_valid=0.
  - perf_flush increments on each edge with redirect_valid=1.
  - All counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then load words 0..3 with addi x1..x4, then release → cycles 1–4: pc_if_id=0,4,8,12; instruction_if_id matches memory; valid_if_id=1; PC=16 after cycle 4.
2. stall=1 for 2 cycles while PC=8 → PC stays 8, IF/ID holds word 1 (pc_if_id=4); after release, word 2 appears with pc_if_id=8.
3. stall=1 and redirect_valid=1 with redirect_pc=0x40 on the same edge → PC=0x40, instruction_if_id=0x00000013, valid_if_id=0; next edge pc_if_id=0x40.
4. Word 5 = 0x00000073 → pc_if_id=0x14 holds ECALL, halted=1, then NOP/valid 0 indefinitely; then redirect_pc=0x8 → halted=0, fetch resumes at 0x8.
5. IMEM_DEPTH=4, free-run from 0 → words at 0..0xC delivered, then fetch_fault=1, PC stays 0x10, valid_if_id=0; reset pulse low mid-fault → all outputs at reset values without a clock edge.
6. With FETCH_PERF_EN: 4 fetches, 2 stall cycles, 1 redirect → perf_fetched=4, perf_stall=2, perf_flush=1.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: owns the PC, reads instr_mem combinationally, stops fetch on ECALL/bad PC.
// Latency: 1 cycle IF->ID. Stall holds PC and IF/ID; redirect flushes and overrides stall. Option: FETCH_PERF_EN.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] PC,
    output logic [31:0] instruction_if_id,
    output logic [63:0] pc_if_id,
    output logic        valid_if_id,
    output logic        halted,
    output logic        fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int          AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [63:0] IMEM_BYTES = 64'(IMEM_DEPTH) * 64'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Loaded from outside (bench hierarchical writes); never written by this block.
    logic [31:0] instr_mem [IMEM_DEPTH];

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [63:0] pcid_q, pcid_d;
    logic        vld_q, vld_d;

    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic          pc_in_range;
    logic          fetch_go;

    assign fetch_idx   = pc_q[AW+1:2];
    assign fetch_word  = instr_mem[fetch_idx];
    assign pc_in_range = (pc_q < IMEM_BYTES) && (pc_q[1:0] == 2'b00);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        pcid_d   = pcid_q;
        vld_d    = vld_q;
        fetch_go = 1'b0;
        if (redirect_valid) begin
            // Redirect also cancels a HALT/FAULT raised on a wrong-path fetch.
            pc_d    = redirect_pc;
            ins_d   = NOP_INSTR;
            pcid_d  = 64'h0;
            vld_d   = 1'b0;
            state_d = ST_RUN;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!pc_in_range) begin
                        state_d = ST_FAULT;
                        ins_d   = NOP_INSTR;
                        vld_d   = 1'b0;
                    end else begin
                        fetch_go = 1'b1;
                        ins_d    = fetch_word;
                        pcid_d   = pc_q;
                        vld_d    = 1'b1;
                        if (fetch_word == HALT_INSTR) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_q + 64'd4;
                        end
                    end
                end
                default: begin
                    ins_d = NOP_INSTR;
                    vld_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ins_q   <= NOP_INSTR;
            pcid_q  <= 64'h0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pcid_q  <= pcid_d;
            vld_q   <= vld_d;
        end
    end

    assign PC                = pc_q;
    assign instruction_if_id = ins_q;
    assign pc_if_id          = pcid_q;
    assign valid_if_id       = vld_q;
    assign halted            = (state_q == ST_HALT);
    assign fetch_fault       = (state_q == ST_FAULT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        perf_flush_d   = perf_flush_q;
        if (fetch_go && perf_fetched_q != 32'hFFFFFFFF) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (stall && !redirect_valid && perf_stall_q != 32'hFFFFFFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_valid && perf_flush_q != 32'hFFFFFFFF) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
            perf_flush_q   <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule
